// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide engine.
//   muldiv_op_t    : RV32M funct3 encodings
//   muldiv_state_t : sequencer states
//   muldiv_ctl_t   : per-instruction control latched when an op is accepted
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // op[2] separates the divide group from the multiply group
  localparam int MULDIV_DIV_BIT = 2;

  typedef struct packed {
    logic [2:0] op;
    logic       sign_a;
    logic       sign_b;
  } muldiv_ctl_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> muldiv handshake bundle.
//   master : EX side (drives start/flush/op/operands, sees stall/result)
//   slave  : muldiv unit
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall_req;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, op, a, b,
    input  stall_req, busy, result_valid, result
  );

  modport slave (
    input  start, flush, op, a, b,
    output stall_req, busy, result_valid, result
  );
endinterface

// File: rtl/ex_muldiv_unit_iter_step.sv
// One radix-2 iteration of the shared shift/add-subtract datapath (combinational).
//   acc_i/acc_o     : high half (product high / partial remainder)
//   shreg_i/shreg_o : low half (multiplier->product low / dividend->quotient)
//   opnd_i          : multiplicand or divisor magnitude
//   is_div          : select restoring divide step instead of shift-add
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] shreg_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic            is_div,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] shreg_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] t;
  logic [XLEN:0] diff;

  always_comb begin
    // multiply: add multiplicand if LSB set, shift {carry,acc,shreg} right
    sum = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    // divide: shift next dividend bit into remainder, trial-subtract
    t    = {acc_i, shreg_i[XLEN-1]};
    diff = t - {1'b0, opnd_i};
    if (is_div) begin
      // remainder stays below the divisor, so it always fits XLEN bits
      acc_o   = diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0];
      shreg_o = {shreg_i[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_o   = sum[XLEN:1];
      shreg_o = {sum[0], shreg_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine beside the EX-stage ALU.
// Holds EX via stall_req until the result is ready, then presents result
// with result_valid for one cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   mif        : muldiv_if.slave (start, flush, op, a, b ->
//                stall_req, busy, result_valid, result)
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave mif
);

  localparam int RUN_CYC = XLEN / STEPS_PER_CYCLE;
  localparam int CW      = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_FIN  = 2'(FIN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] shreg;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] result_q;
  muldiv_ctl_t     ctl;

  // ---------------- operand decode (IDLE) ----------------
  logic            accept;
  logic            in_div, a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0, ovf, fast;
  logic [XLEN-1:0] fast_res;

  assign accept = mif.start & ~mif.flush;
  assign in_div = mif.op[MULDIV_DIV_BIT];

  always_comb begin
    // a signed for MUL/MULH/MULHSU/DIV/REM; b signed for MUL/MULH/DIV/REM
    a_sgn = in_div ? ~mif.op[0] : (mif.op != 3'(MULHU));
    b_sgn = in_div ? ~mif.op[0] : ~mif.op[1];
    sa    = a_sgn & mif.a[XLEN-1];
    sb    = b_sgn & mif.b[XLEN-1];
    mag_a = sa ? -mif.a : mif.a;
    mag_b = sb ? -mif.b : mif.b;

    div0 = in_div & (mif.b == '0);
    ovf  = in_div & ~mif.op[0] & (mif.a == {1'b1, {(XLEN-1){1'b0}}}) &
           (mif.b == '1);
    fast = div0 | ovf;

    // op[1] picks REM/REMU over DIV/DIVU
    if (div0) fast_res = mif.op[1] ? mif.a : '1;
    else      fast_res = mif.op[1] ? '0    : mif.a;
  end

  // ---------------- iteration chain ----------------
  logic [STEPS_PER_CYCLE:0][XLEN-1:0] acc_c;
  logic [STEPS_PER_CYCLE:0][XLEN-1:0] shr_c;

  assign acc_c[0] = acc;
  assign shr_c[0] = shreg;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .acc_i   (acc_c[g]),
      .shreg_i (shr_c[g]),
      .opnd_i  (opnd),
      .is_div  (ctl.op[MULDIV_DIV_BIT]),
      .acc_o   (acc_c[g+1]),
      .shreg_o (shr_c[g+1])
    );
  end

  // ---------------- sign fix + output select (FIN) ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;

  always_comb begin
    prod_s = (ctl.sign_a ^ ctl.sign_b) ? -{acc, shreg} : {acc, shreg};
    quo_s  = (ctl.sign_a ^ ctl.sign_b) ? -shreg : shreg;
    rem_s  = ctl.sign_a ? -acc : acc;
    fin_res = '0;
    unique case (ctl.op)
      3'(MUL):                      fin_res = prod_s[XLEN-1:0];
      3'(MULH), 3'(MULHSU), 3'(MULHU): fin_res = prod_s[2*XLEN-1:XLEN];
      3'(DIV), 3'(DIVU):            fin_res = quo_s;
      default:                      fin_res = rem_s;
    endcase
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      result_q <= '0;
      ctl      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          ctl <= '{op: mif.op, sign_a: sa, sign_b: sb};
          cnt <= '0;
          if (fast) begin
            result_q <= fast_res;
            state    <= S_DONE;
          end else begin
            // multiply: shreg = multiplier, opnd = multiplicand
            // divide:   shreg = dividend,   opnd = divisor
            acc   <= '0;
            shreg <= in_div ? mag_a : mag_b;
            opnd  <= in_div ? mag_b : mag_a;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (mif.flush) state <= S_IDLE;
          else begin
            acc   <= acc_c[STEPS_PER_CYCLE];
            shreg <= shr_c[STEPS_PER_CYCLE];
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(RUN_CYC-1)) state <= S_FIN;
          end
        end
        S_FIN: begin
          if (mif.flush) state <= S_IDLE;
          else begin
            result_q <= fin_res;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE; // DONE: start still belongs to this op
      endcase
    end
  end

  // ---------------- outputs ----------------
  logic stall;

  always_comb begin
    stall = 1'b0;
    unique case (state)
      S_IDLE:       stall = accept;
      S_RUN, S_FIN: stall = 1'b1;  // held through a flush cycle too
      default:      stall = 1'b0;
    endcase
  end

  assign mif.stall_req    = rst_n & stall;
  assign mif.busy         = rst_n & (state != S_IDLE);
  assign mif.result_valid = (state == S_DONE);
  assign mif.result       = result_q;

endmodule
